// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Purpose  : Shared NoC router constants: flit layout, buffer depth, port IDs
//            and the output-link state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package noc_pkg;

   // Flit layout: [22:7] payload, [6:3] address, [2:0] target port
   localparam int FLIT_W      = 23;
   localparam int PAYLOAD_MSB = 22;
   localparam int PAYLOAD_LSB = 7;
   localparam int ADDR_MSB    = 6;
   localparam int ADDR_LSB    = 3;
   localparam int TGT_MSB     = 2;
   localparam int TGT_LSB     = 0;
   localparam int TGT_W       = TGT_MSB - TGT_LSB + 1;

   // Depth of every router input buffer; also the credit ceiling of a link
   localparam int BUF_DEPTH   = 7;

   // Output port indices
   localparam logic [2:0] PORT_LOCAL = 3'd0;
   localparam logic [2:0] PORT_NORTH = 3'd1;
   localparam logic [2:0] PORT_EAST  = 3'd2;
   localparam logic [2:0] PORT_SOUTH = 3'd3;
   localparam logic [2:0] PORT_WEST  = 3'd4;

   // Output link state as seen through the credit counter
   typedef enum logic [0:0] {
      LINK_BLOCKED = 1'b0,
      LINK_OPEN    = 1'b1
   } link_state_e;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/noc_output_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : noc_output_arbiter_if
// Purpose  : Bundle of input-buffer heads, pop strobes, output link and
//            credit return for one router output port.
// Revision : 1.0 - initial release
// ============================================================================
interface noc_output_arbiter_if
   import noc_pkg::*;
#(
   parameter int NUM_IN = 5,
   parameter int FLIT_W = noc_pkg::FLIT_W
);

   logic [NUM_IN-1:0]        in_valid;
   logic [NUM_IN*FLIT_W-1:0] in_flit;
   logic [NUM_IN-1:0]        in_pop;
   logic [FLIT_W-1:0]        out_flit;
   logic                     out_valid;
   logic                     credit_in;
   logic [2:0]               credit_cnt;
   logic                     err_credit;

   // Arbiter side: consumes buffer heads and credits, drives the link
   modport master (
      input  in_valid, in_flit, credit_in,
      output in_pop, out_flit, out_valid, credit_cnt, err_credit
   );

   // Environment side: input buffers and downstream router
   modport slave (
      output in_valid, in_flit, credit_in,
      input  in_pop, out_flit, out_valid, credit_cnt, err_credit
   );

endinterface : noc_output_arbiter_if
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. Searches from i_rr_ptr
//            upward with wrap-around and returns a one-hot grant plus its
//            encoded index. Reusable by any router allocator.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import noc_pkg::*;
#(
   parameter int NUM_IN = 5,
   parameter int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  wire logic [NUM_IN-1:0] i_req,
   input  wire logic [IDX_W-1:0]  i_rr_ptr,
   input  wire logic              i_enable,
   output logic      [NUM_IN-1:0] o_grant,
   output logic      [IDX_W-1:0]  o_idx,
   output logic                   o_valid
);

   // Two ordered passes: first indices at or above the pointer, then the
   // wrapped indices below it; the first requester found wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      if (i_enable) begin
         for (int j = 0; j < NUM_IN; j++) begin
            if (!o_valid && i_req[j] && (j >= int'(i_rr_ptr))) begin
               o_grant[j] = 1'b1;
               o_idx      = IDX_W'(j);
               o_valid    = 1'b1;
            end
         end
         for (int j = 0; j < NUM_IN; j++) begin
            if (!o_valid && i_req[j]) begin
               o_grant[j] = 1'b1;
               o_idx      = IDX_W'(j);
               o_valid    = 1'b1;
            end
         end
      end
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/noc_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : noc_output_arbiter
// Purpose  : Per-output-port switch allocator. Round-robin among buffer heads
//            targeting PORT_ID, pops the winner, registers the flit onto the
//            link and gates grants with a downstream credit counter.
// Revision : 1.0 - initial release
// ============================================================================
module noc_output_arbiter
   import noc_pkg::*;
#(
   parameter int         NUM_IN  = 5,
   parameter logic [2:0] PORT_ID = 3'd0,
   parameter int         FLIT_W  = noc_pkg::FLIT_W,
   parameter int         CREDITS = noc_pkg::BUF_DEPTH
) (
   input wire logic              clk,
   input wire logic              rst,   // synchronous, active-low
   noc_output_arbiter_if.master  bus
);

   localparam int         IDX_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam logic [2:0] CREDIT_MAX = 3'(CREDITS);

   logic [NUM_IN-1:0] w_req;
   logic [NUM_IN-1:0] w_grant;
   logic [IDX_W-1:0]  w_idx;
   logic              w_gnt;
   logic              w_enable;
   link_state_e       w_link_state;
   logic [FLIT_W-1:0] w_sel_flit;
   logic [IDX_W-1:0]  w_ptr_next;
   logic [2:0]        w_cnt_next;
   logic              w_credit_ovf;

   logic [FLIT_W-1:0] r_out_flit;
   logic              r_out_valid;
   logic [IDX_W-1:0]  r_rr_ptr;
   logic [2:0]        r_credit_cnt;
   logic              r_err_credit;

   // A head requests only when valid and addressed to this output port
   generate
      for (genvar i = 0; i < NUM_IN; i++) begin : g_req
         assign w_req[i] = bus.in_valid[i] &&
                           (bus.in_flit[i*FLIT_W + TGT_LSB +: TGT_W] == PORT_ID);
      end
   endgenerate

   // Link is blocked when downstream has no free slot; grants are also held
   // off while reset is asserted so no buffer is popped during reset.
   assign w_link_state = (r_credit_cnt == 3'd0) ? LINK_BLOCKED : LINK_OPEN;
   assign w_enable     = (w_link_state == LINK_OPEN) && rst;

   rr_arbiter #(
      .NUM_IN (NUM_IN),
      .IDX_W  (IDX_W)
   ) u_rr_arbiter (
      .i_req    (w_req),
      .i_rr_ptr (r_rr_ptr),
      .i_enable (w_enable),
      .o_grant  (w_grant),
      .o_idx    (w_idx),
      .o_valid  (w_gnt)
   );

   // One-hot AND-OR mux of the winning head flit
   always_comb begin
      w_sel_flit = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         w_sel_flit = w_sel_flit | (bus.in_flit[i*FLIT_W +: FLIT_W] & {FLIT_W{w_grant[i]}});
      end
   end

   // Priority moves to the index just past the winner, wrapping to zero
   assign w_ptr_next = (w_idx == IDX_W'(NUM_IN - 1)) ? '0 : (w_idx + IDX_W'(1));

   // Credit count = count - grant + credit_in, saturating at the ceiling
   always_comb begin
      w_cnt_next   = r_credit_cnt;
      w_credit_ovf = 1'b0;
      if (w_gnt && !bus.credit_in) begin
         w_cnt_next = r_credit_cnt - 3'd1;
      end else if (!w_gnt && bus.credit_in) begin
         if (r_credit_cnt == CREDIT_MAX) begin
            w_credit_ovf = 1'b1;
         end else begin
            w_cnt_next = r_credit_cnt + 3'd1;
         end
      end
   end

   // Output link register, round-robin pointer, credit counter, sticky error
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_out_flit   <= '0;
         r_out_valid  <= 1'b0;
         r_rr_ptr     <= '0;
         r_credit_cnt <= CREDIT_MAX;
         r_err_credit <= 1'b0;
      end else begin
         r_out_valid  <= w_gnt;
         r_credit_cnt <= w_cnt_next;
         if (w_gnt) begin
            r_out_flit <= w_sel_flit;
            r_rr_ptr   <= w_ptr_next;
         end
         if (w_credit_ovf) begin
            r_err_credit <= 1'b1;
         end
      end
   end

   assign bus.in_pop     = w_grant;
   assign bus.out_flit   = r_out_flit;
   assign bus.out_valid  = r_out_valid;
   assign bus.credit_cnt = r_credit_cnt;
   assign bus.err_credit = r_err_credit;

endmodule : noc_output_arbiter
`default_nettype wire
